// File: rtl/pm_fetch_if.sv
// Program-memory read port plus the instruction hand-off to execute.
// The fetch sequencer is the master; memory and execute sit on the slave side.
interface pm_fetch_if;
  logic [7:0] pm_addr;
  logic [7:0] pm_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_op;
  logic [7:0] instr_b1;
  logic [7:0] instr_b2;
  logic [1:0] instr_len;
  logic [7:0] instr_pc;
  logic       illegal;
  logic       halted;

  modport master (
    output pm_addr,
    input  pm_data,
    output instr_valid,
    input  instr_ready,
    output instr_op,
    output instr_b1,
    output instr_b2,
    output instr_len,
    output instr_pc,
    output illegal,
    output halted
  );

  modport slave (
    input  pm_addr,
    output pm_data,
    input  instr_valid,
    output instr_ready,
    input  instr_op,
    input  instr_b1,
    input  instr_b2,
    input  instr_len,
    input  instr_pc,
    input  illegal,
    input  halted
  );
endinterface

// File: rtl/pm_fetch_sequencer.sv
// Byte-serial instruction fetch: assembles 1-3 byte instructions,
// resolves JMP locally and issues one instruction at a time.
module pm_fetch_sequencer #(
  parameter logic [7:0] END_ADDR = 8'd14,
  parameter logic [7:0] RESET_PC = 8'd0
) (
  input logic        clk,
  input logic        rst,
  pm_fetch_if.master bus
);

  localparam logic [7:0] OP_JMP = 8'h07;

  typedef enum logic [2:0] {
    FETCH_OP,
    FETCH_B1,
    FETCH_B2,
    ISSUE,
    HALT
  } state_t;

  state_t     state, state_d;
  logic [7:0] pc, pc_d;
  logic [7:0] op, op_d;
  logic [7:0] b1, b1_d;
  logic [7:0] b2, b2_d;
  logic [1:0] len, len_d;
  logic [7:0] ipc, ipc_d;
  logic       ill, ill_d;

  function automatic logic [2:0] decode(input logic [7:0] o);
    logic [2:0] r;
    unique case (1'b1)
      (o == 8'h00), (o == 8'h06): r = 3'b011;
      (o == 8'h01), (o == 8'h03),
      (o == 8'h07):               r = 3'b010;
      (o == 8'h12):               r = 3'b001;
      default:                    r = 3'b101;
    endcase
    return r;
  endfunction

  logic [2:0] dec;
  assign dec = decode(bus.pm_data);

  always_comb begin
    state_d = state;
    pc_d    = pc;
    op_d    = op;
    b1_d    = b1;
    b2_d    = b2;
    len_d   = len;
    ipc_d   = ipc;
    ill_d   = ill;
    unique case (state)
      FETCH_OP: begin
        if (pc >= END_ADDR) begin
          state_d = HALT;
        end else begin
          op_d    = bus.pm_data;
          ipc_d   = pc;
          b1_d    = 8'h00;
          b2_d    = 8'h00;
          len_d   = dec[1:0];
          ill_d   = dec[2];
          pc_d    = pc + 8'd1;
          state_d = (dec[1:0] > 2'd1) ? FETCH_B1 : ISSUE;
        end
      end
      FETCH_B1: begin
        b1_d = bus.pm_data;
        // JMP is consumed here and never reaches execute
        if (op == OP_JMP) begin
          pc_d    = bus.pm_data;
          state_d = FETCH_OP;
        end else begin
          pc_d    = pc + 8'd1;
          state_d = (len == 2'd3) ? FETCH_B2 : ISSUE;
        end
      end
      FETCH_B2: begin
        b2_d    = bus.pm_data;
        pc_d    = pc + 8'd1;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (bus.instr_ready) state_d = FETCH_OP;
      end
      HALT: state_d = HALT;
      default: state_d = FETCH_OP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH_OP;
      pc    <= RESET_PC;
      op    <= 8'h00;
      b1    <= 8'h00;
      b2    <= 8'h00;
      len   <= 2'd0;
      ipc   <= 8'h00;
      ill   <= 1'b0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      op    <= op_d;
      b1    <= b1_d;
      b2    <= b2_d;
      len   <= len_d;
      ipc   <= ipc_d;
      ill   <= ill_d;
    end
  end

  assign bus.pm_addr     = pc;
  assign bus.instr_valid = (state == ISSUE);
  assign bus.instr_op    = op;
  assign bus.instr_b1    = b1;
  assign bus.instr_b2    = b2;
  assign bus.instr_len   = len;
  assign bus.instr_pc    = ipc;
  assign bus.illegal     = ill;
  assign bus.halted      = (state == HALT);

endmodule

// File: tb/tb_pm_fetch_sequencer.sv
// Directed bench for pm_fetch_sequencer against a small program ROM.
module tb_pm_fetch_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] mem [256];
  logic watch2 = 1'b0;
  logic saw2 = 1'b0;

  pm_fetch_if bus ();

  pm_fetch_sequencer #(.END_ADDR(8'd14), .RESET_PC(8'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.pm_data = mem[bus.pm_addr];

  always @(posedge clk)
    if (watch2 && !rst && bus.pm_addr == 8'd2) saw2 <= 1'b1;

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic load_std();
    clear_mem();
    mem[0] = 8'h07; mem[1] = 8'h03; mem[2] = 8'h01;
    mem[3] = 8'h03; mem[4] = 8'h14;
    mem[5] = 8'h06; mem[6] = 8'h07; mem[7] = 8'h02;
    mem[8] = 8'h01; mem[9] = 8'h02;
    mem[10] = 8'h12;
    mem[11] = 8'h00; mem[12] = 8'h03; mem[13] = 8'h02;
  endtask

  task automatic release_rst();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    load_std();
    bus.instr_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.halted !== 1'b0 || bus.pm_addr !== 8'd0 ||
        bus.instr_op !== 8'd0 || bus.instr_len !== 2'd0 || bus.illegal !== 1'b0 ||
        bus.instr_pc !== 8'd0 || bus.instr_b1 !== 8'd0 || bus.instr_b2 !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b halted=%b addr=%h op=%h len=%0d ill=%b",
               bus.instr_valid, bus.halted, bus.pm_addr, bus.instr_op,
               bus.instr_len, bus.illegal);
    end
  endtask

  task automatic test_standard();
    logic [7:0] e_op [5];
    logic [7:0] e_b1 [5];
    logic [7:0] e_b2 [5];
    logic [1:0] e_len [5];
    logic [7:0] e_pc [5];
    int e_lat [5];
    int n;
    e_op = '{8'h03, 8'h06, 8'h01, 8'h12, 8'h00};
    e_b1 = '{8'h14, 8'h07, 8'h02, 8'h00, 8'h03};
    e_b2 = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h02};
    e_len = '{2'd2, 2'd3, 2'd2, 2'd1, 2'd3};
    e_pc = '{8'd3, 8'd5, 8'd8, 8'd10, 8'd11};
    e_lat = '{4, 4, 3, 2, 4};
    load_std();
    bus.instr_ready = 1'b1;
    saw2 = 1'b0;
    watch2 = 1'b1;
    release_rst();
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!bus.instr_valid && n < 30);
      checks++;
      if (n != e_lat[k]) begin
        errors++;
        $display("FAIL std_latency[%0d]: got %0d cycles, want %0d", k, n, e_lat[k]);
      end
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_op !== e_op[k] ||
          bus.instr_b1 !== e_b1[k] || bus.instr_b2 !== e_b2[k] ||
          bus.instr_len !== e_len[k] || bus.instr_pc !== e_pc[k] ||
          bus.illegal !== 1'b0) begin
        errors++;
        $display("FAIL std_issue[%0d]: got v=%b op=%h b1=%h b2=%h len=%0d pc=%0d ill=%b, want op=%h b1=%h b2=%h len=%0d pc=%0d",
                 k, bus.instr_valid, bus.instr_op, bus.instr_b1, bus.instr_b2,
                 bus.instr_len, bus.instr_pc, bus.illegal,
                 e_op[k], e_b1[k], e_b2[k], e_len[k], e_pc[k]);
      end
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.halted !== 1'b1 || bus.pm_addr !== 8'd14 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL std_halt: halted=%b addr=%0d valid=%b, want 1 14 0",
               bus.halted, bus.pm_addr, bus.instr_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.halted !== 1'b1 || bus.pm_addr !== 8'd14) begin
      errors++;
      $display("FAIL std_halt_hold: halted=%b addr=%0d, want 1 14",
               bus.halted, bus.pm_addr);
    end
    watch2 = 1'b0;
    checks++;
    if (saw2 !== 1'b0) begin
      errors++;
      $display("FAIL std_skip_addr2: fetched addr 2 = %b, want 0", saw2);
    end
  endtask

  task automatic test_backpressure();
    int n;
    load_std();
    bus.instr_ready = 1'b1;
    release_rst();
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.instr_valid && n < 30);
    @(posedge clk); #1;
    bus.instr_ready = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.instr_valid && n < 30);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'd5) begin
      errors++;
      $display("FAIL bp_reach: valid=%b pc=%0d, want 1 5", bus.instr_valid, bus.instr_pc);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_op !== 8'h06 || bus.instr_b1 !== 8'h07 ||
          bus.instr_b2 !== 8'h02 || bus.instr_len !== 2'd3 || bus.instr_pc !== 8'd5 ||
          bus.pm_addr !== 8'd8) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v=%b op=%h b1=%h b2=%h len=%0d pc=%0d addr=%0d",
                 c, bus.instr_valid, bus.instr_op, bus.instr_b1, bus.instr_b2,
                 bus.instr_len, bus.instr_pc, bus.pm_addr);
      end
    end
    bus.instr_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.pm_addr !== 8'd8) begin
      errors++;
      $display("FAIL bp_accept: valid=%b addr=%0d, want 0 8", bus.instr_valid, bus.pm_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.instr_op !== 8'h01 || bus.instr_pc !== 8'd8 || bus.pm_addr !== 8'd9) begin
      errors++;
      $display("FAIL bp_next_fetch: op=%h pc=%0d addr=%0d, want 01 8 9",
               bus.instr_op, bus.instr_pc, bus.pm_addr);
    end
  endtask

  task automatic test_illegal();
    clear_mem();
    mem[0] = 8'hFF;
    mem[1] = 8'h12;
    bus.instr_ready = 1'b1;
    release_rst();
    @(posedge clk); #1;
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_op !== 8'hFF || bus.instr_len !== 2'd1 ||
        bus.illegal !== 1'b1 || bus.instr_pc !== 8'd0 || bus.instr_b1 !== 8'd0 ||
        bus.pm_addr !== 8'd1) begin
      errors++;
      $display("FAIL illegal_issue: v=%b op=%h len=%0d ill=%b pc=%0d addr=%0d",
               bus.instr_valid, bus.instr_op, bus.instr_len, bus.illegal,
               bus.instr_pc, bus.pm_addr);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.instr_op !== 8'h12 || bus.instr_pc !== 8'd1 || bus.illegal !== 1'b0 ||
        bus.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL illegal_next: op=%h pc=%0d ill=%b v=%b, want 12 1 0 1",
               bus.instr_op, bus.instr_pc, bus.illegal, bus.instr_valid);
    end
  endtask

  task automatic test_jmp_halt();
    logic saw_valid;
    clear_mem();
    mem[0] = 8'h07;
    mem[1] = 8'h20;
    bus.instr_ready = 1'b1;
    saw_valid = 1'b0;
    release_rst();
    @(posedge clk); #1;
    saw_valid |= bus.instr_valid;
    @(posedge clk); #1;
    saw_valid |= bus.instr_valid;
    checks++;
    if (bus.pm_addr !== 8'h20 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL jmp_target: addr=%h halted=%b, want 20 0", bus.pm_addr, bus.halted);
    end
    @(posedge clk); #1;
    saw_valid |= bus.instr_valid;
    checks++;
    if (bus.halted !== 1'b1 || bus.pm_addr !== 8'h20) begin
      errors++;
      $display("FAIL jmp_halt: halted=%b addr=%h, want 1 20", bus.halted, bus.pm_addr);
    end
    repeat (3) begin
      @(posedge clk); #1;
      saw_valid |= bus.instr_valid;
    end
    checks++;
    if (saw_valid !== 1'b0 || bus.halted !== 1'b1) begin
      errors++;
      $display("FAIL jmp_no_issue: saw_valid=%b halted=%b, want 0 1", saw_valid, bus.halted);
    end
  endtask

  task automatic test_reset_midflight();
    int n;
    load_std();
    bus.instr_ready = 1'b1;
    release_rst();
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (bus.pm_addr !== 8'd7 || bus.instr_op !== 8'h06) begin
      errors++;
      $display("FAIL rst_b2_setup: addr=%0d op=%h, want 7 06", bus.pm_addr, bus.instr_op);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.pm_addr !== 8'd0 || bus.instr_op !== 8'd0 ||
        bus.instr_b1 !== 8'd0 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_b2: v=%b addr=%0d op=%h b1=%h halted=%b",
               bus.instr_valid, bus.pm_addr, bus.instr_op, bus.instr_b1, bus.halted);
    end
    bus.instr_ready = 1'b0;
    release_rst();
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.instr_valid && n < 30);
    checks++;
    if (n != 4 || bus.instr_op !== 8'h03 || bus.instr_pc !== 8'd3) begin
      errors++;
      $display("FAIL rst_restart1: cycles=%0d op=%h pc=%0d, want 4 03 3",
               n, bus.instr_op, bus.instr_pc);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.pm_addr !== 8'd0 || bus.instr_len !== 2'd0 ||
        bus.instr_pc !== 8'd0) begin
      errors++;
      $display("FAIL rst_in_issue: v=%b addr=%0d len=%0d pc=%0d",
               bus.instr_valid, bus.pm_addr, bus.instr_len, bus.instr_pc);
    end
    bus.instr_ready = 1'b1;
    release_rst();
    @(posedge clk); #1;
    checks++;
    if (bus.instr_op !== 8'h07 || bus.pm_addr !== 8'd1) begin
      errors++;
      $display("FAIL rst_restart2: op=%h addr=%0d, want 07 1", bus.instr_op, bus.pm_addr);
    end
  endtask

  initial begin
    bus.instr_ready = 1'b1;
    clear_mem();
    test_reset();
    test_standard();
    test_backpressure();
    test_illegal();
    test_jmp_halt();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pm_fetch_sequencer.md
Name: pm_fetch_sequencer

Overview:
Instruction fetch controller for the 8-bit Harvard CPU. Drives the program memory address, reads its combinational 8-bit output one byte per cycle, and assembles variable-length instructions (1–3 bytes). It resolves JMP internally and hands each complete instruction to the execute stage over a valid/ready handshake. Sits between the program memory and the decoder/ALU controller.

Parameters:
END_ADDR, 8'd14, first address past the loaded program; fetching an opcode at or beyond it enters HALT.
RESET_PC, 8'd0, PC value after reset.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
pm_addr  output  8  program memory address (combinational = current fetch pointer)
pm_data  input  8  program memory read data, valid in the same cycle as pm_addr
instr_valid  output  1  assembled instruction available
instr_ready  input  1  execute stage accepts the instruction
instr_op  output  8  opcode byte
instr_b1  output  8  operand byte 1 (0 if unused)
instr_b2  output  8  operand byte 2 (0 if unused)
instr_len  output  2  instruction length in bytes (1..3)
instr_pc  output  8  address of the opcode byte
illegal  output  1  issued opcode is not in the opcode table
halted  output  1  sequencer is in HALT

Behaviour:
- Opcode table (length): 0x00 MOV mem→reg 3; 0x01 ADD 2; 0x03 MOV reg→reg 2; 0x06 MOV imm→reg 3; 0x07 JMP 2; 0x12 CLR Acc 1. Any other value: length 1, illegal=1.
- States: FETCH_OP, FETCH_B1, FETCH_B2, ISSUE, HALT.
- Reset (asynchronous, any state): state=FETCH_OP, pc=RESET_PC, and all instr_* outputs, illegal and halted are 0.
- pm_addr = pc at all times. Each fetch state samples pm_data at the clock edge and advances pc by 1 (8-bit, 0xFF wraps to 0x00).
- FETCH_OP: if pc ≥ END_ADDR, go to HALT with no read. Otherwise latch op; set instr_pc=pc; clear b1/b2; go to FETCH_B1 if length >1, else ISSUE.
- FETCH_B1: latch b1. For JMP, load pc=pm_data (no increment) and go to FETCH_OP; JMP is never issued. For other opcodes, go to FETCH_B2 if length=3, else ISSUE.
- FETCH_B2: latch b2; go to ISSUE.
- ISSUE: instr_valid=1 and all instr_* outputs stable. When instr_ready=1, the instruction transfers at that edge, valid drops, and the state goes to FETCH_OP. Without ready, hold indefinitely. pc does not change during ISSUE.
- Latency (ready tied high): 1-byte instruction: valid 1 cycle after the opcode cycle; 2-byte: 2 cycles; 3-byte: 3 cycles. Throughput = length+1 cycles per instruction. JMP costs 2 cycles with no issue.
- HALT: halted=1, valid=0, pm_addr holds. Leave only via rst.
- A JMP whose target is ≥ END_ADDR enters HALT on the next FETCH_OP.
- No fetch of a new opcode overlaps ISSUE (single-instruction buffer). Deasserting instr_ready while valid is high must not alter outputs.

Test Plan:
- Standard program (0:07 03 01, 3:03 14, 5:06 07 02, 8:01 02, 10:12, 11:00 03 02), ready=1, release rst → first issue op=0x03 b1=0x14 len=2 instr_pc=3, valid 4 cycles after reset release; addr 2 is never fetched.
- Same run → issue sequence: (06,07,02,len3,pc5), (01,02,len2,pc8), (12,len1,pc10,b1=b2=0), (00,03,02,len3,pc11), then halted=1 with pm_addr=14.
- Backpressure: hold instr_ready=0 for 5 cycles at the pc=5 issue → outputs constant and pm_addr=8 throughout; accept on ready → next fetch at addr 8.
- Illegal opcode 0xFF at addr 0 → issue op=0xFF len=1 illegal=1, then fetch at addr 1.
- JMP target 0x20 (≥END_ADDR) → halted=1 two cycles later, no valid pulse.
- Assert rst during FETCH_B2 and again during ISSUE with ready=0 → valid=0, pc=RESET_PC immediately, and fetch restarts at 0 after release.
